// File: rtl/n64_flashram.sv
// rtl/n64_flashram.sv - N64 FlashRAM save device emulation behind the PI, with SDRAM erase/program engine
//
// Emulates the 128 KiB FlashRAM (8 sectors x 128 pages x 128 B). PI command
// and status accesses are decoded here. The page program buffer lives here.
// Erase and program traffic is issued as single outstanding SDRAM writes.
// Array reads bypass this block: o_read_array tells the PI to route
// flashram-window reads straight to the SDRAM save area.
//
// Optional feature macro: FLASHRAM_CHIP_ERASE_EN
//   defined   - opcode 0x3C latches a whole-chip erase target
//   undefined - 0x3C is ignored like any unknown opcode, and the erase
//               counter is only as wide as one sector
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_enable            flashram enabled (cart control)
//   i_request, i_write  PI access strobe and direction (flashram bank)
//   i_address[14:0]     PI word address; bit 14 selects the command register
//   i_data[31:0]        PI write data
//   o_busy              always 0, accesses are accepted on the same cycle
//   o_ack, o_data       one-cycle completion pulse and read data
//   o_read_array        registered: mode is READ_ARRAY
//   o_mem_*             SDRAM write master (request/busy/ack handshake)

`timescale 1ns/1ps

`ifndef BANK_SDRAM
`define BANK_SDRAM 4'd1
`endif

module n64_flashram #(
    parameter logic [23:0] SAVE_BASE = 24'h7F8000,
    parameter logic [3:0]  MEM_BANK  = `BANK_SDRAM
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_request,
    input  logic        i_write,
    output logic        o_busy,
    output logic        o_ack,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_read_array,
    output logic        o_mem_request,
    output logic        o_mem_write,
    input  logic        i_mem_busy,
    input  logic        i_mem_ack,
    output logic [3:0]  o_mem_bank,
    output logic [23:0] o_mem_address,
    output logic [31:0] o_mem_data
);

    typedef enum logic [1:0] {
        MODE_READ_ARRAY,
        MODE_STATUS,
        MODE_ID,
        MODE_PAGE_LOAD
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    localparam logic [7:0] OP_SECTOR_ERASE = 8'h4B;
    localparam logic [7:0] OP_CHIP_ERASE   = 8'h3C;
    localparam logic [7:0] OP_ERASE_START  = 8'h78;
    localparam logic [7:0] OP_PAGE_LOAD    = 8'hB4;
    localparam logic [7:0] OP_PROGRAM      = 8'hA5;
    localparam logic [7:0] OP_STATUS       = 8'hD2;
    localparam logic [7:0] OP_ID           = 8'hE1;
    localparam logic [7:0] OP_READ_ARRAY   = 8'hF0;

    localparam logic [31:0] ID_WORD0 = 32'h1111_8001;
    localparam logic [31:0] ID_WORD1 = 32'h00C2_001E;

    // The word counter must span the largest operation that can be started.
`ifdef FLASHRAM_CHIP_ERASE_EN
    localparam int CNT_W = 15;
`else
    localparam int CNT_W = 12;
`endif

    mode_t              mode;
    state_t             state;
    logic               erase_busy;
    logic               program_busy;
    logic               erase_done;
    logic               program_done;
    logic               target_valid;
    logic [2:0]         target_sector;
`ifdef FLASHRAM_CHIP_ERASE_EN
    logic               target_chip;
`endif
    logic               op_program;
    logic [CNT_W-1:0]   word_count;
    logic [CNT_W-1:0]   last_count;
    logic [CNT_W-1:0]   next_count;
    logic [31:0]        buffer [32];

    logic [7:0]         opcode;
    logic [9:0]         arg;
    logic               engine_busy;
    logic               mode_cmd;
    logic               cmd_write;
    logic               cmd_accept;
    logic               buf_write;
    logic               erase_start;
    logic               program_start;
    logic [31:0]        status_word;
    logic [31:0]        read_word;
    logic               unused_bits;

    assign o_busy      = 1'b0;
    assign o_mem_write = 1'b1;
    assign o_mem_bank  = MEM_BANK;

    assign opcode = i_data[31:24];
    assign arg    = i_data[9:0];

    // DONE is a single bookkeeping cycle; a new start may be taken there, so
    // only the cycles with traffic in flight count as busy.
    assign engine_busy = (state == ST_ISSUE) || (state == ST_WAIT_ACK);

    // Mode switches stay usable while an operation runs so software can poll
    // status or leave ID mode without waiting.
    assign mode_cmd   = (opcode == OP_STATUS) || (opcode == OP_ID) || (opcode == OP_READ_ARRAY);
    assign cmd_write  = i_request && i_enable && i_write && i_address[14];
    assign cmd_accept = cmd_write && (!engine_busy || mode_cmd);
    assign buf_write  = i_request && i_enable && i_write && !i_address[14]
                        && (mode == MODE_PAGE_LOAD) && !engine_busy;

    assign erase_start   = cmd_accept && (opcode == OP_ERASE_START) && target_valid;
    assign program_start = cmd_accept && (opcode == OP_PROGRAM);

    assign status_word = {28'h0, erase_done, program_done, erase_busy, program_busy};

    always_comb begin
        read_word = 32'h0;
        if (i_enable) begin
            if (mode == MODE_ID) begin
                read_word = i_address[0] ? ID_WORD1 : ID_WORD0;
            end else begin
                read_word = status_word;
            end
        end
    end

    assign next_count = word_count + CNT_W'(1);

    // Only the low address bits select a buffer word; the rest of the window
    // and the upper argument bits carry no meaning for this device.
    assign unused_bits = ^{i_address[13:5], i_data[23:10]};

    // Page buffer has no reset: its contents are undefined until loaded.
    always_ff @(posedge i_clk) begin
        if (buf_write) begin
            buffer[i_address[4:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ack         <= 1'b0;
            o_data        <= 32'h0;
            o_read_array  <= 1'b1;
            o_mem_request <= 1'b0;
            o_mem_address <= 24'h0;
            o_mem_data    <= 32'h0;
            mode          <= MODE_READ_ARRAY;
            state         <= ST_IDLE;
            erase_busy    <= 1'b0;
            program_busy  <= 1'b0;
            erase_done    <= 1'b0;
            program_done  <= 1'b0;
            target_valid  <= 1'b0;
            target_sector <= 3'd0;
`ifdef FLASHRAM_CHIP_ERASE_EN
            target_chip   <= 1'b0;
`endif
            op_program    <= 1'b0;
            word_count    <= '0;
            last_count    <= '0;
        end else begin
            // PI side: every access completes on the following cycle; read
            // data reflects the state before this cycle's updates.
            o_ack <= i_request;
            if (i_request) begin
                o_data <= i_write ? 32'h0 : read_word;
            end

            if (cmd_accept) begin
                case (opcode)
                    OP_SECTOR_ERASE: begin
                        target_valid  <= 1'b1;
                        target_sector <= arg[9:7];
`ifdef FLASHRAM_CHIP_ERASE_EN
                        target_chip   <= 1'b0;
`endif
                    end
`ifdef FLASHRAM_CHIP_ERASE_EN
                    OP_CHIP_ERASE: begin
                        target_valid <= 1'b1;
                        target_chip  <= 1'b1;
                    end
`endif
                    OP_PAGE_LOAD: begin
                        mode         <= MODE_PAGE_LOAD;
                        o_read_array <= 1'b0;
                    end
                    OP_STATUS: begin
                        mode         <= MODE_STATUS;
                        o_read_array <= 1'b0;
                    end
                    OP_ID: begin
                        mode         <= MODE_ID;
                        o_read_array <= 1'b0;
                    end
                    OP_READ_ARRAY: begin
                        mode         <= MODE_READ_ARRAY;
                        o_read_array <= 1'b1;
                    end
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (erase_start) begin
                        state         <= ST_ISSUE;
                        o_mem_request <= 1'b1;
                        o_mem_data    <= 32'hFFFF_FFFF;
                        op_program    <= 1'b0;
                        word_count    <= '0;
                        erase_busy    <= 1'b1;
                        erase_done    <= 1'b0;
                        program_done  <= 1'b0;
`ifdef FLASHRAM_CHIP_ERASE_EN
                        if (target_chip) begin
                            o_mem_address <= SAVE_BASE;
                            last_count    <= CNT_W'(32767);
                        end else
`endif
                        begin
                            o_mem_address <= SAVE_BASE + {9'b0, target_sector, 12'b0};
                            last_count    <= CNT_W'(4095);
                        end
                    end else if (program_start) begin
                        state         <= ST_ISSUE;
                        o_mem_request <= 1'b1;
                        o_mem_address <= SAVE_BASE + {9'b0, arg, 5'b0};
                        o_mem_data    <= buffer[0];
                        op_program    <= 1'b1;
                        word_count    <= '0;
                        last_count    <= CNT_W'(31);
                        program_busy  <= 1'b1;
                        erase_done    <= 1'b0;
                        program_done  <= 1'b0;
                    end
                end

                // Address and data stay put until the arbiter takes the write.
                ST_ISSUE: begin
                    if (!i_mem_busy) begin
                        o_mem_request <= 1'b0;
                        state         <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (i_mem_ack) begin
                        if (word_count == last_count) begin
                            state <= ST_DONE;
                            if (op_program) begin
                                program_busy <= 1'b0;
                                program_done <= 1'b1;
                            end else begin
                                erase_busy   <= 1'b0;
                                erase_done   <= 1'b1;
                                target_valid <= 1'b0;
                            end
                        end else begin
                            state         <= ST_ISSUE;
                            o_mem_request <= 1'b1;
                            word_count    <= next_count;
                            o_mem_address <= o_mem_address + 24'd1;
                            o_mem_data    <= op_program ? buffer[next_count[4:0]] : 32'hFFFF_FFFF;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
